// File: rtl/mdio_master.sv
// mdio_master: MDIO management master (Clause 22 / Clause 45).
//
// Takes one register request at a time over a valid/ready handshake. It
// serialises the frame on MDC/MDIO as preamble, ST, OP, PHYAD/PRTAD,
// REGAD/DEVAD, TA and 16 data bits, MSB first. It then returns a one-cycle
// response carrying read data and a turnaround error flag. The MDIO tristate
// buffer lives at board top level, so the pin is exposed as o/oe/i.
//
// Parameters:
//   CLK_DIV  sys0_clk cycles per MDC half-period (1..255)
//   PRE_LEN  preamble '1' bits before ST (0..32)
//
// Optional build macro:
//   MDIO_PRE_SUPPRESS_EN  adds input pre_suppress. When it is high at accept,
//                         the frame is sent without a preamble.
//
// Ports:
//   sys0_clk, sys0_rst      clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_c45, req_op         frame type and OP field (OP MSB=1 means read)
//   req_phyad, req_regad    PHYAD/PRTAD and REGAD/DEVAD
//   req_data                write data or C45 address
//   rsp_valid               one-cycle pulse at the end of every frame
//   rsp_data, rsp_err       read data and bad-turnaround flag (held)
//   mdio_mdc                management clock
//   mdio_mdd_o/_oe/_i       MDIO pad output, output enable, input
module mdio_master #(
  parameter int CLK_DIV = 25,
  parameter int PRE_LEN = 32
) (
  input  logic        sys0_clk,
  input  logic        sys0_rst,
`ifdef MDIO_PRE_SUPPRESS_EN
  input  logic        pre_suppress,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_c45,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_phyad,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        mdio_mdc,
  output logic        mdio_mdd_o,
  output logic        mdio_mdd_oe,
  input  logic        mdio_mdd_i
);

  typedef enum logic [1:0] {IDLE, PRE, FRAME, DONE} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] PRE_BITS = 6'(PRE_LEN);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [5:0]  pre_n_q, pre_n_d;
  logic        rd_q, rd_d;
  logic [31:0] frame_q, frame_d;
  logic [15:0] rx_q, rx_d;
  logic        ta_q, ta_d;
  logic        mdc_q, mdc_d;
  logic        mdo_q, mdo_d;
  logic        oe_q, oe_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept;
  logic        half_end;
  logic        rise;
  logic        fall;
  logic [5:0]  bit_nxt;
  logic [5:0]  pre_sel;
  logic [5:0]  ta1_idx;
  logic [5:0]  ta2_idx;
  logic [5:0]  last_idx;
  logic [31:0] frame_in;

`ifdef MDIO_PRE_SUPPRESS_EN
  assign pre_sel = pre_suppress ? 6'd0 : PRE_BITS;
`else
  assign pre_sel = PRE_BITS;
`endif

  assign accept   = req_valid && ready_q;
  assign half_end = (div_q == DIV_LAST);
  // MDC toggles at the end of each half-period; the level before the toggle
  // tells which edge is about to happen.
  assign rise     = half_end && !mdc_q;
  assign fall     = half_end && mdc_q;
  assign bit_nxt  = bit_q + 6'd1;
  // The bit counter runs across preamble and frame, so frame-relative
  // positions are offset by this frame's preamble length.
  assign ta1_idx  = pre_n_q + 6'd14;
  assign ta2_idx  = pre_n_q + 6'd15;
  assign last_idx = pre_n_q + 6'd31;
  // The TA field is always loaded as 10. On reads it is never seen on the
  // wire, because the output enable is already off by then.
  assign frame_in = {(req_c45 ? 2'b00 : 2'b01), req_op, req_phyad, req_regad,
                     2'b10, req_data};

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    pre_n_d     = pre_n_q;
    rd_d        = rd_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    ta_d        = ta_q;
    mdc_d       = mdc_q;
    mdo_d       = mdo_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pre_n_d = pre_sel;
          rd_d    = req_op[1];
          frame_d = frame_in;
          div_d   = 8'd0;
          bit_d   = 6'd0;
          mdc_d   = 1'b0;
          oe_d    = 1'b1;
          if (pre_sel == 6'd0) begin
            state_d = FRAME;
            mdo_d   = frame_in[31];
          end else begin
            state_d = PRE;
            mdo_d   = 1'b1;
          end
        end
      end

      PRE, FRAME: begin
        if (half_end) begin
          div_d = 8'd0;
          mdc_d = ~mdc_q;
        end else begin
          div_d = div_q + 8'd1;
        end

        // PHY data is captured as MDC goes high: TA2 first, then 16 data bits.
        if (rise && (state_q == FRAME) && rd_q) begin
          if (bit_q == ta2_idx) begin
            ta_d = mdio_mdd_i;
          end else if (bit_q > ta2_idx) begin
            rx_d = {rx_q[14:0], mdio_mdd_i};
          end
        end

        // New bits are launched only as MDC falls.
        if (fall) begin
          if (state_q == PRE) begin
            bit_d = bit_nxt;
            if (bit_q == pre_n_q - 6'd1) begin
              state_d = FRAME;
              mdo_d   = frame_q[31];
            end
          end else if (bit_q == last_idx) begin
            state_d     = DONE;
            mdc_d       = 1'b0;
            oe_d        = 1'b0;
            mdo_d       = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_q ? rx_q : 16'h0000;
            rsp_err_d   = rd_q & ta_q;
          end else begin
            bit_d   = bit_nxt;
            frame_d = {frame_q[30:0], 1'b0};
            mdo_d   = frame_q[30];
            if (rd_q && (bit_nxt >= ta1_idx)) begin
              oe_d = 1'b0;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge sys0_clk) begin
    if (sys0_rst) begin
      state_q     <= IDLE;
      div_q       <= 8'd0;
      bit_q       <= 6'd0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b1;
      oe_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      oe_q        <= oe_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Frame payload and capture registers: always rewritten before use.
  always_ff @(posedge sys0_clk) begin
    pre_n_q <= pre_n_d;
    rd_q    <= rd_d;
    frame_q <= frame_d;
    rx_q    <= rx_d;
    ta_q    <= ta_d;
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign mdio_mdc    = mdc_q;
  assign mdio_mdd_o  = mdo_q;
  assign mdio_mdd_oe = oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Testbench for mdio_master: randomized and directed C22/C45 frames checked
// against a bit-level frame model and a simple PHY responder.
module tb_mdio_master;

  localparam int CLK_DIV = 2;
  localparam int PRE_LEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_c45 = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [4:0]  req_phyad = 5'd0;
  logic [4:0]  req_regad = 5'd0;
  logic [15:0] req_data = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        mdio_mdc;
  logic        mdio_mdd_o;
  logic        mdio_mdd_oe;
  logic        mdio_mdd_i = 1'b1;
`ifdef MDIO_PRE_SUPPRESS_EN
  logic        pre_suppress = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
    .sys0_clk    (clk),
    .sys0_rst    (rst),
`ifdef MDIO_PRE_SUPPRESS_EN
    .pre_suppress(pre_suppress),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_c45     (req_c45),
    .req_op      (req_op),
    .req_phyad   (req_phyad),
    .req_regad   (req_regad),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .mdio_mdc    (mdio_mdc),
    .mdio_mdd_o  (mdio_mdd_o),
    .mdio_mdd_oe (mdio_mdd_oe),
    .mdio_mdd_i  (mdio_mdd_i)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Waits for ready, presents the request for one accept edge, then returns
  // just after that edge (req_valid stays high when hold is set).
  task automatic do_accept(input logic c45, input logic [1:0] op, input logic [4:0] phyad,
                           input logic [4:0] regad, input logic [15:0] data, input logic hold);
    int w = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
    end
    req_c45   = c45;
    req_op    = op;
    req_phyad = phyad;
    req_regad = regad;
    req_data  = data;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Follows one frame from the cycle after accept. It checks every serial bit
  // at MDC rise against the expected stream and plays the PHY for reads. It
  // then checks latency, DONE pins, the response and the single idle cycle.
  task automatic monitor_frame(input logic c45, input logic [1:0] op, input logic [4:0] phyad,
                               input logic [4:0] regad, input logic [15:0] data,
                               input logic ta2, input logic [15:0] rdata,
                               input int pre_n, input string name);
    int n;
    int lat;
    int c = 0;
    int k = 0;
    int bit_err = 0;
    int oe_err = 0;
    int idx;
    logic prev_mdc = 1'b0;
    logic got = 1'b0;
    logic rd;
    logic exp_bit;
    logic exp_oe;
    logic phy_bit;
    logic [31:0] f;
    n   = pre_n + 32;
    lat = 1 + n * 2 * CLK_DIV;
    rd  = op[1];
    f   = {(c45 ? 2'b00 : 2'b01), op, phyad, regad, 2'b10, data};
    while (!got && c < lat + 20) begin
      @(negedge clk);
      c++;
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        if (mdio_mdc === 1'b1 && prev_mdc === 1'b0) begin
          if (k < n) begin
            if (k < pre_n) exp_bit = 1'b1;
            else begin
              idx = 31 - (k - pre_n);
              exp_bit = f[idx];
            end
            exp_oe = !(rd && (k >= pre_n + 14));
            if (mdio_mdd_oe !== exp_oe) oe_err++;
            if (exp_oe && (mdio_mdd_o !== exp_bit)) bit_err++;
          end
          k++;
        end
        prev_mdc = mdio_mdc;
        phy_bit = 1'b1;
        if (rd && k == pre_n + 15) phy_bit = ta2;
        else if (rd && k >= pre_n + 16 && k < n) begin
          idx = 15 - (k - pre_n - 16);
          phy_bit = rdata[idx];
        end
        mdio_mdd_i = phy_bit;
      end
    end
    mdio_mdd_i = 1'b1;

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s rsp_timeout: no rsp_valid within %0d cycles", name, lat + 20);
    end
    checks++;
    if (c != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, c, lat);
    end
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL %s bit_count: got %0d mdc rises required %0d", name, k, n);
    end
    checks++;
    if (bit_err != 0) begin
      errors++;
      $display("FAIL %s stream: %0d wrong driven bits required 0", name, bit_err);
    end
    checks++;
    if (oe_err != 0) begin
      errors++;
      $display("FAIL %s oe: %0d wrong oe samples required 0", name, oe_err);
    end
    checks++;
    if ({mdio_mdc, mdio_mdd_oe, mdio_mdd_o} !== 3'b001) begin
      errors++;
      $display("FAIL %s done_pins: mdc/oe/o=%b%b%b required 001", name, mdio_mdc, mdio_mdd_oe, mdio_mdd_o);
    end
    checks++;
    if (rsp_data !== (rd ? rdata : 16'h0000)) begin
      errors++;
      $display("FAIL %s rsp_data: got %h required %h", name, rsp_data, rd ? rdata : 16'h0000);
    end
    checks++;
    if (rsp_err !== (rd & ta2)) begin
      errors++;
      $display("FAIL %s rsp_err: got %b required %b", name, rsp_err, rd & ta2);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready, mdio_mdc} !== 3'b010) begin
      errors++;
      $display("FAIL %s idle_after: valid/ready/mdc=%b%b%b required 010", name, rsp_valid, req_ready, mdio_mdc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mdio_mdc, mdio_mdd_oe, mdio_mdd_o, req_ready, rsp_valid, rsp_err} !== 6'b001000 ||
        rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: mdc/oe/o/ready/valid/err=%b%b%b%b%b%b data=%h required 001000 0000",
               mdio_mdc, mdio_mdd_oe, mdio_mdd_o, req_ready, rsp_valid, rsp_err, rsp_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_c22_write();
    do_accept(1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b0);
    monitor_frame(1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, PRE_LEN, "c22_write");
  endtask

  task automatic test_c22_read();
    do_accept(1'b0, 2'b10, 5'h07, 5'h02, 16'hFFFF, 1'b0);
    monitor_frame(1'b0, 2'b10, 5'h07, 5'h02, 16'hFFFF, 1'b0, 16'h0141, PRE_LEN, "c22_read");
    do_accept(1'b0, 2'b10, 5'h07, 5'h02, 16'h0000, 1'b0);
    monitor_frame(1'b0, 2'b10, 5'h07, 5'h02, 16'h0000, 1'b1, 16'h0141, PRE_LEN, "c22_read_ta_err");
  endtask

  task automatic test_random_writes();
    logic c45;
    logic [1:0] op;
    logic [4:0] pa;
    logic [4:0] ra;
    logic [15:0] d;
    for (int i = 0; i < 5; i++) begin
      c45 = 1'($urandom_range(0, 1));
      op  = c45 ? 2'($urandom_range(0, 1)) : 2'b01;
      pa  = 5'($urandom);
      ra  = 5'($urandom);
      d   = 16'($urandom);
      do_accept(c45, op, pa, ra, d, 1'b0);
      monitor_frame(c45, op, pa, ra, d, 1'b0, 16'h0000, PRE_LEN, "rand_write");
    end
  endtask

  task automatic test_random_reads();
    logic c45;
    logic [1:0] op;
    logic [4:0] pa;
    logic [4:0] ra;
    logic [15:0] d;
    logic [15:0] rdat;
    logic ta2;
    for (int i = 0; i < 5; i++) begin
      c45  = 1'($urandom_range(0, 1));
      op   = c45 ? ($urandom_range(0, 1) != 0 ? 2'b11 : 2'b10) : 2'b10;
      pa   = 5'($urandom);
      ra   = 5'($urandom);
      d    = 16'($urandom);
      rdat = 16'($urandom);
      ta2  = ($urandom_range(0, 3) == 0);
      do_accept(c45, op, pa, ra, d, 1'b0);
      monitor_frame(c45, op, pa, ra, d, ta2, rdat, PRE_LEN, "rand_read");
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pa;
    logic [4:0] ra;
    logic [15:0] rdat;
    pa   = 5'($urandom);
    ra   = 5'($urandom);
    rdat = 16'($urandom);
    do_accept(1'b1, 2'b00, pa, ra, 16'h000D, 1'b1);
    req_op   = 2'b11;
    req_data = 16'h0000;
    monitor_frame(1'b1, 2'b00, pa, ra, 16'h000D, 1'b0, 16'h0000, PRE_LEN, "b2b_addr");
    fork
      monitor_frame(1'b1, 2'b11, pa, ra, 16'h0000, 1'b0, rdat, PRE_LEN, "b2b_read");
      begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
      end
    join
  endtask

  task automatic test_reset_abort();
    int k = 0;
    int c = 0;
    int seen = 0;
    logic prev = 1'b0;
    do_accept(1'b0, 2'b01, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0);
    while (k < 20 && c < 400) begin
      @(negedge clk);
      c++;
      if (mdio_mdc === 1'b1 && prev === 1'b0) k++;
      prev = mdio_mdc;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mdio_mdc, mdio_mdd_oe, mdio_mdd_o, rsp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL abort_pins: mdc/oe/o/valid=%b%b%b%b required 0010",
               mdio_mdc, mdio_mdd_oe, mdio_mdd_o, rsp_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: req_ready=%b required 1", req_ready);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_rsp: %0d rsp_valid pulses required 0", seen);
    end
    do_accept(1'b0, 2'b01, 5'h03, 5'h04, 16'hA5C3, 1'b0);
    monitor_frame(1'b0, 2'b01, 5'h03, 5'h04, 16'hA5C3, 1'b0, 16'h0000, PRE_LEN, "after_abort");
  endtask

`ifdef MDIO_PRE_SUPPRESS_EN
  task automatic test_pre_suppress();
    logic [15:0] rdat;
    rdat = 16'($urandom);
    pre_suppress = 1'b1;
    do_accept(1'b1, 2'b11, 5'h05, 5'h01, 16'h0000, 1'b0);
    pre_suppress = 1'b0;
    monitor_frame(1'b1, 2'b11, 5'h05, 5'h01, 16'h0000, 1'b0, rdat, 0, "pre_suppress");
  endtask
`endif

  initial begin
    test_reset();
    test_c22_write();
    test_c22_read();
    test_random_writes();
    test_random_reads();
    test_back_to_back();
    test_reset_abort();
`ifdef MDIO_PRE_SUPPRESS_EN
    test_pre_suppress();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
